// File: rtl/ir_key_proc.sv
// ir_key_proc: turns the NEC decoder's frame/repeat strobes into clean key
// events (press, auto-repeat, release), a held-key level and an error count.
// Optional feature macro: IR_ADDR_CHECK_EN. When defined, the address byte
// and its complement must match DEV_ADDR. When undefined, any remote is
// accepted.
`timescale 1ns/1ps
module ir_key_proc #(
  parameter logic [23:0] REL_TIMEOUT  = 24'd6_500_000,
  parameter int unsigned REPEAT_DELAY = 4,
  parameter int unsigned REPEAT_RATE  = 1,
  parameter logic [7:0]  DEV_ADDR     = 8'h00
) (
  input  logic        SYSCLK,
  input  logic        RST_B,
  input  logic [31:0] IR_DATA,
  input  logic        IR_EN,
  output logic [7:0]  KEY_CODE,
  output logic        KEY_PRESS,
  output logic        KEY_REPT,
  output logic        KEY_REL,
  output logic        KEY_HOLD,
  output logic [7:0]  ERR_CNT
);

  // A zero delay or rate would mean "repeat before any strobe", so both are
  // clamped to at least 1. Values above the 8-bit counter range are capped.
  localparam logic [7:0] DELAY_EFF = (REPEAT_DELAY == 0) ? 8'd1 :
                                     (REPEAT_DELAY > 255) ? 8'd255 : 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_EFF  = (REPEAT_RATE == 0) ? 8'd1 :
                                     (REPEAT_RATE > 255) ? 8'd255 : 8'(REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, HELD, AUTO, SWAP} state_t;

  state_t      r_state;
  logic [23:0] r_tmr;
  logic [7:0]  r_rcnt;
  logic [7:0]  r_keyCode;
  logic [7:0]  r_nextCode;
  logic        r_press;
  logic        r_rept;
  logic        r_rel;
  logic [7:0]  r_errCnt;

  state_t      w_stateNext;
  logic [23:0] w_tmrNext;
  logic [7:0]  w_rcntNext;
  logic [7:0]  w_keyCodeNext;
  logic [7:0]  w_nextCodeNext;
  logic        w_pressNext;
  logic        w_reptNext;
  logic        w_relNext;
  logic [7:0]  w_errNext;

  logic [7:0]  w_cmd;
  logic        w_cmdOk;
  logic        w_addrOk;
  logic        w_valid;
  logic        w_invalid;
  logic [7:0]  w_rcntInc;
  logic [7:0]  w_target;

  assign w_cmd   = IR_DATA[15:8];
  assign w_cmdOk = (IR_DATA[15:8] == ~IR_DATA[7:0]);

`ifdef IR_ADDR_CHECK_EN
  assign w_addrOk = (IR_DATA[31:24] == DEV_ADDR) && (IR_DATA[23:16] == ~DEV_ADDR);
`else
  // Address bytes are deliberately ignored in this build.
  logic w_unusedAddr;
  assign w_unusedAddr = ^{IR_DATA[31:16], DEV_ADDR};
  assign w_addrOk     = 1'b1;
`endif

  assign w_valid   = IR_EN & w_cmdOk & w_addrOk;
  assign w_invalid = IR_EN & ~(w_cmdOk & w_addrOk);
  assign w_rcntInc = (r_rcnt == 8'hFF) ? 8'hFF : r_rcnt + 8'd1;
  assign w_target  = (r_state == AUTO) ? RATE_EFF : DELAY_EFF;

  // Next-state and next-output decode; every pulse is computed here and
  // registered below so all outputs leave the block from flops.
  always_comb begin
    w_stateNext    = r_state;
    w_tmrNext      = r_tmr;
    w_rcntNext     = r_rcnt;
    w_keyCodeNext  = r_keyCode;
    w_nextCodeNext = r_nextCode;
    w_pressNext    = 1'b0;
    w_reptNext     = 1'b0;
    w_relNext      = 1'b0;
    w_errNext      = r_errCnt;

    if ((r_state != SWAP) && w_invalid && (r_errCnt != 8'hFF)) begin
      w_errNext = r_errCnt + 8'd1;
    end

    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_keyCodeNext = w_cmd;
          w_pressNext   = 1'b1;
          w_tmrNext     = REL_TIMEOUT;
          w_rcntNext    = 8'd0;
          w_stateNext   = HELD;
        end
      end
      HELD, AUTO: begin
        if (w_valid && (w_cmd == r_keyCode)) begin
          w_tmrNext = REL_TIMEOUT;
          if (w_rcntInc >= w_target) begin
            w_reptNext  = 1'b1;
            w_rcntNext  = 8'd0;
            w_stateNext = AUTO;
          end else begin
            w_rcntNext = w_rcntInc;
          end
        end else if (w_valid) begin
          w_relNext      = 1'b1;
          w_nextCodeNext = w_cmd;
          w_stateNext    = SWAP;
        end else if (r_tmr == 24'd0) begin
          w_relNext   = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_tmrNext = r_tmr - 24'd1;
        end
      end
      SWAP: begin
        w_keyCodeNext = r_nextCode;
        w_pressNext   = 1'b1;
        w_tmrNext     = REL_TIMEOUT;
        w_rcntNext    = 8'd0;
        w_stateNext   = HELD;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset silently drops any held key.
  always_ff @(posedge SYSCLK) begin
    if (!RST_B) begin
      r_state    <= IDLE;
      r_tmr      <= 24'd0;
      r_rcnt     <= 8'd0;
      r_keyCode  <= 8'h00;
      r_nextCode <= 8'h00;
      r_press    <= 1'b0;
      r_rept     <= 1'b0;
      r_rel      <= 1'b0;
      r_errCnt   <= 8'h00;
    end else begin
      r_state    <= w_stateNext;
      r_tmr      <= w_tmrNext;
      r_rcnt     <= w_rcntNext;
      r_keyCode  <= w_keyCodeNext;
      r_nextCode <= w_nextCodeNext;
      r_press    <= w_pressNext;
      r_rept     <= w_reptNext;
      r_rel      <= w_relNext;
      r_errCnt   <= w_errNext;
    end
  end

  assign KEY_CODE  = r_keyCode;
  assign KEY_PRESS = r_press;
  assign KEY_REPT  = r_rept;
  assign KEY_REL   = r_rel;
  assign KEY_HOLD  = (r_state != IDLE);
  assign ERR_CNT   = r_errCnt;

endmodule

// File: tb/tb_ir_key_proc.sv
// tb_ir_key_proc: directed scenarios plus a randomized run of ir_key_proc
// against a gap-counting key model. Honours IR_ADDR_CHECK_EN like the DUT.
`timescale 1ns/1ps
module tb_ir_key_proc;

  localparam int REL   = 100;
  localparam int DELAY = 4;
  localparam int RATE  = 2;

  logic        SYSCLK = 1'b0;
  logic        RST_B  = 1'b0;
  logic [31:0] IR_DATA = 32'h0;
  logic        IR_EN  = 1'b0;
  logic [7:0]  KEY_CODE;
  logic        KEY_PRESS;
  logic        KEY_REPT;
  logic        KEY_REL;
  logic        KEY_HOLD;
  logic [7:0]  ERR_CNT;

  int checks   = 0;
  int failures = 0;

  ir_key_proc #(
    .REL_TIMEOUT (24'd100),
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE),
    .DEV_ADDR    (8'h00)
  ) dut (
    .SYSCLK   (SYSCLK),
    .RST_B    (RST_B),
    .IR_DATA  (IR_DATA),
    .IR_EN    (IR_EN),
    .KEY_CODE (KEY_CODE),
    .KEY_PRESS(KEY_PRESS),
    .KEY_REPT (KEY_REPT),
    .KEY_REL  (KEY_REL),
    .KEY_HOLD (KEY_HOLD),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Reference model: a key is held until REL quiet cycles have passed after
  // the last accepted strobe; repeats are counted in strobes since the press.
  bit         mHeld = 0, mSwap = 0, mAuto = 0;
  logic [7:0] mCode = 8'h00, mNext = 8'h00;
  int         mQuiet = 0, mCount = 0, mErr = 0;
  bit         ePress = 0, eRept = 0, eRel = 0;

  function automatic bit frameOk(input logic [31:0] d);
    bit ok;
    ok = (d[15:8] == ~d[7:0]);
`ifdef IR_ADDR_CHECK_EN
    ok = ok && (d[31:24] == 8'h00) && (d[23:16] == 8'hFF);
`endif
    return ok;
  endfunction

  task automatic modelStep();
    ePress = 0; eRept = 0; eRel = 0;
    if (!RST_B) begin
      mHeld = 0; mSwap = 0; mAuto = 0; mCode = 8'h00;
      mQuiet = 0; mCount = 0; mErr = 0;
    end else if (mSwap) begin
      mSwap = 0; mCode = mNext; ePress = 1; mQuiet = 0; mCount = 0; mAuto = 0;
    end else begin
      if (IR_EN && !frameOk(IR_DATA) && mErr < 255) mErr++;
      if (IR_EN && frameOk(IR_DATA)) begin
        if (!mHeld) begin
          mHeld = 1; mCode = IR_DATA[15:8]; ePress = 1;
          mQuiet = 0; mCount = 0; mAuto = 0;
        end else if (IR_DATA[15:8] == mCode) begin
          mQuiet = 0;
          mCount++;
          if (mCount >= (mAuto ? RATE : DELAY)) begin
            eRept = 1; mCount = 0; mAuto = 1;
          end
        end else begin
          eRel = 1; mNext = IR_DATA[15:8]; mSwap = 1;
        end
      end else if (mHeld) begin
        if (mQuiet == REL) begin
          eRel = 1; mHeld = 0;
        end else begin
          mQuiet++;
        end
      end
    end
  endtask

  // One clock: the model sees the same inputs the DUT samples, outputs are
  // read 1 ns after the edge.
  task automatic tick();
    @(posedge SYSCLK);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] d);
    IR_DATA = d;
    IR_EN   = 1'b1;
    tick();
    IR_EN   = 1'b0;
  endtask

  task automatic doReset();
    IR_EN = 1'b0;
    RST_B = 1'b0;
    tick();
    RST_B = 1'b1;
  endtask

  task automatic test_reset();
    IR_EN = 1'b0;
    RST_B = 1'b0;
    tick();
    tick();
    checks++;
    if ({KEY_CODE, KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_outputs actual=%h expected=000",
               {KEY_CODE, KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD});
    end
    checks++;
    if (ERR_CNT !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_errcnt actual=%h expected=00", ERR_CNT);
    end
    RST_B = 1'b1;
    tick();
    checks++;
    if ({KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_quiet actual=%b expected=0000",
               {KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD});
    end
  endtask

  task automatic test_press_release();
    int relAt = 0;
    int other = 0;
    int holdDrop = 0;
    logic [7:0] relCode = 8'h00;
    doReset();
    applyStimulus(32'h00FF45BA);
    checks++;
    if (KEY_PRESS !== 1'b1) begin
      failures++;
      $display("[TB] FAIL press_pulse actual=%b expected=1", KEY_PRESS);
    end
    checks++;
    if (KEY_CODE !== 8'h45) begin
      failures++;
      $display("[TB] FAIL press_code actual=%h expected=45", KEY_CODE);
    end
    checks++;
    if (KEY_HOLD !== 1'b1) begin
      failures++;
      $display("[TB] FAIL press_hold actual=%b expected=1", KEY_HOLD);
    end
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (KEY_REL === 1'b1) begin
        relAt = k;
        relCode = KEY_CODE;
        break;
      end
      if (KEY_PRESS === 1'b1 || KEY_REPT === 1'b1) other++;
      if (KEY_HOLD !== 1'b1) holdDrop++;
    end
    checks++;
    if (relAt != REL + 1) begin
      failures++;
      $display("[TB] FAIL release_latency actual=%0d expected=%0d", relAt, REL + 1);
    end
    checks++;
    if (relCode !== 8'h45) begin
      failures++;
      $display("[TB] FAIL release_code actual=%h expected=45", relCode);
    end
    checks++;
    if (other != 0 || holdDrop != 0) begin
      failures++;
      $display("[TB] FAIL hold_window stray=%0d holdlow=%0d expected=0/0", other, holdDrop);
    end
    tick();
    checks++;
    if (KEY_HOLD !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_after_release actual=%b expected=0", KEY_HOLD);
    end
  endtask

  task automatic test_auto_repeat();
    int presses = 0;
    int rels = 0;
    int strayRept = 0;
    int relSeen = 0;
    logic [9:0] reptMask = 10'b0;
    doReset();
    for (int s = 0; s < 10; s++) begin
      applyStimulus(32'h00FF45BA);
      if (KEY_PRESS === 1'b1) presses++;
      if (KEY_REPT === 1'b1) reptMask[s] = 1'b1;
      if (KEY_REL === 1'b1) rels++;
      for (int g = 1; g < 50; g++) begin
        tick();
        if (KEY_PRESS === 1'b1) presses++;
        if (KEY_REPT === 1'b1) strayRept++;
        if (KEY_REL === 1'b1) rels++;
      end
    end
    checks++;
    if (presses != 1) begin
      failures++;
      $display("[TB] FAIL repeat_press_count actual=%0d expected=1", presses);
    end
    checks++;
    if (reptMask !== 10'b01_0101_0000 || strayRept != 0) begin
      failures++;
      $display("[TB] FAIL repeat_pattern actual=%b stray=%0d expected=0101010000",
               reptMask, strayRept);
    end
    checks++;
    if (rels != 0) begin
      failures++;
      $display("[TB] FAIL repeat_early_release actual=%0d expected=0", rels);
    end
    for (int k = 0; k < 200; k++) begin
      tick();
      if (KEY_REL === 1'b1) begin
        relSeen = 1;
        break;
      end
    end
    checks++;
    if (relSeen != 1) begin
      failures++;
      $display("[TB] FAIL repeat_final_release actual=%0d expected=1", relSeen);
    end
  endtask

  task automatic test_bad_complement();
    int pulses = 0;
    doReset();
    applyStimulus(32'h00FF4545);
    checks++;
    if ({KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL bad_no_event actual=%b expected=0000",
               {KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD});
    end
    checks++;
    if (ERR_CNT !== 8'h01) begin
      failures++;
      $display("[TB] FAIL bad_errcnt actual=%h expected=01", ERR_CNT);
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(32'h00FF4545);
      if (KEY_PRESS === 1'b1 || KEY_HOLD === 1'b1) pulses++;
    end
    checks++;
    if (ERR_CNT !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL err_saturate actual=%h expected=ff", ERR_CNT);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL bad_stream_events actual=%0d expected=0", pulses);
    end
  endtask

  task automatic test_key_change();
    int relSeen = 0;
    doReset();
    applyStimulus(32'h00FF45BA);
    repeat (19) tick();
    applyStimulus(32'h00FF16E9);
    checks++;
    if (KEY_REL !== 1'b1 || KEY_PRESS !== 1'b0 || KEY_CODE !== 8'h45) begin
      failures++;
      $display("[TB] FAIL change_release actual=rel%b press%b code%h expected=rel1 press0 code45",
               KEY_REL, KEY_PRESS, KEY_CODE);
    end
    checks++;
    if (KEY_HOLD !== 1'b1) begin
      failures++;
      $display("[TB] FAIL change_hold_swap actual=%b expected=1", KEY_HOLD);
    end
    applyStimulus(32'h00FF1616);
    checks++;
    if (KEY_PRESS !== 1'b1 || KEY_REL !== 1'b0 || KEY_CODE !== 8'h16) begin
      failures++;
      $display("[TB] FAIL change_press actual=press%b rel%b code%h expected=press1 rel0 code16",
               KEY_PRESS, KEY_REL, KEY_CODE);
    end
    checks++;
    if (ERR_CNT !== 8'h00) begin
      failures++;
      $display("[TB] FAIL swap_ignores_strobe actual=%h expected=00", ERR_CNT);
    end
    for (int k = 0; k < 200; k++) begin
      tick();
      if (KEY_REL === 1'b1) begin
        relSeen = 1;
        break;
      end
    end
    checks++;
    if (relSeen != 1) begin
      failures++;
      $display("[TB] FAIL change_final_release actual=%0d expected=1", relSeen);
    end
  endtask

  task automatic test_timeout_collision();
    int early = 0;
    int relAt = 0;
    doReset();
    applyStimulus(32'h00FF45BA);
    for (int k = 0; k < REL; k++) begin
      tick();
      if (KEY_REL === 1'b1) early++;
    end
    applyStimulus(32'h00FF45BA);
    checks++;
    if (KEY_REL !== 1'b0 || KEY_HOLD !== 1'b1 || early != 0) begin
      failures++;
      $display("[TB] FAIL collision_no_release actual=rel%b hold%b early%0d expected=rel0 hold1 early0",
               KEY_REL, KEY_HOLD, early);
    end
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (KEY_REL === 1'b1) begin
        relAt = k;
        break;
      end
    end
    checks++;
    if (relAt != REL + 1) begin
      failures++;
      $display("[TB] FAIL collision_reload actual=%0d expected=%0d", relAt, REL + 1);
    end
  endtask

  task automatic test_reset_mid_hold();
    int sawRept = 0;
    int relAfter = 0;
    doReset();
    for (int s = 0; s < 5; s++) begin
      applyStimulus(32'h00FF45BA);
      if (KEY_REPT === 1'b1) sawRept++;
      tick();
      tick();
    end
    checks++;
    if (sawRept != 1) begin
      failures++;
      $display("[TB] FAIL midhold_reached_auto actual=%0d expected=1", sawRept);
    end
    RST_B = 1'b0;
    tick();
    RST_B = 1'b1;
    checks++;
    if ({KEY_CODE, KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD, ERR_CNT} !== 20'h00000) begin
      failures++;
      $display("[TB] FAIL midhold_reset_clear actual=%h expected=00000",
               {KEY_CODE, KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD, ERR_CNT});
    end
    for (int k = 0; k < 150; k++) begin
      tick();
      if (KEY_REL === 1'b1 || KEY_HOLD === 1'b1) relAfter++;
    end
    checks++;
    if (relAfter != 0) begin
      failures++;
      $display("[TB] FAIL midhold_no_release actual=%0d expected=0", relAfter);
    end
    applyStimulus(32'h01FE45BA);
`ifdef IR_ADDR_CHECK_EN
    checks++;
    if (ERR_CNT !== 8'h01 || KEY_PRESS !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_reject actual=err%h press%b expected=err01 press0", ERR_CNT, KEY_PRESS);
    end
`else
    checks++;
    if (ERR_CNT !== 8'h00 || KEY_PRESS !== 1'b1 || KEY_CODE !== 8'h45) begin
      failures++;
      $display("[TB] FAIL addr_ignored actual=err%h press%b code%h expected=err00 press1 code45",
               ERR_CNT, KEY_PRESS, KEY_CODE);
    end
`endif
    repeat (REL + 3) tick();
  endtask

  task automatic test_random();
    int gap = 0;
    logic [7:0] codes [3] = '{8'h45, 8'h16, 8'hA7};
    logic [7:0] code;
    logic [7:0] cmdc;
    logic [15:0] addr;
    doReset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      RST_B = ($urandom_range(0, 499) != 0);
      if (gap == 0) begin
        if ($urandom_range(0, 9) >= 3) begin
          code = codes[$urandom_range(0, 2)];
          cmdc = ($urandom_range(0, 9) < 8) ? ~code : code ^ 8'h01;
          addr = ($urandom_range(0, 9) < 8) ? 16'h00FF : 16'($urandom);
          IR_DATA = {addr, code, cmdc};
        end
        IR_EN = 1'b1;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: gap = $urandom_range(0, 8);
          6, 7, 8:          gap = $urandom_range(20, 60);
          default:          gap = $urandom_range(REL - 5, REL + 5);
        endcase
      end else begin
        IR_EN = 1'b0;
        gap--;
      end
      tick();
      checks++;
      if ({KEY_CODE, KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD, ERR_CNT} !==
          {mCode, ePress, eRept, eRel, mHeld, 8'(mErr)}) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d actual=%h expected=%h", cyc,
                 {KEY_CODE, KEY_PRESS, KEY_REPT, KEY_REL, KEY_HOLD, ERR_CNT},
                 {mCode, ePress, eRept, eRel, mHeld, 8'(mErr)});
      end
      checks++;
      if (32'(KEY_PRESS) + 32'(KEY_REPT) + 32'(KEY_REL) > 1) begin
        failures++;
        $display("[TB] FAIL random_pulse_overlap cycle%0d actual=%b expected=at most one",
                 cyc, {KEY_PRESS, KEY_REPT, KEY_REL});
      end
    end
    IR_EN = 1'b0;
    RST_B = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_press_release();
    test_auto_repeat();
    test_bad_complement();
    test_key_change();
    test_timeout_collision();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
